bus_arbiter_rr: RTL and testbench



---
 rtl/bus_arbiter_rr_pkg.sv | 40 ++++
 rtl/bus_arbiter_rr_if.sv | 33 +++
 rtl/bus_arbiter_rr_fifo.sv | 76 +++++++
 rtl/bus_arbiter_rr.sv | 147 ++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_rr_pkg.sv
// Shared types, default parameters and the round-robin search helper for the
// serial bus arbiter and its split-owner table.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GNT_INIT,
        GNT_SPLIT,
        RELEASE
    } arb_state_e;

    localparam int DEF_NUM_INIT  = 2;
    localparam int DEF_NUM_SPLIT = 2;
    localparam int DEF_TIMEOUT   = 64;
    localparam int MAX_INIT      = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of mask at or after ptr, wrapping modulo n. Scanning from the
    // largest offset down lets the smallest offset overwrite the result last.
    function automatic rr_pick_t rr_pick(input logic [MAX_INIT-1:0] mask,
                                         input logic [2:0] ptr,
                                         input int n);
        rr_pick_t r;
        int       j;
        r = '0;
        for (int k = MAX_INIT - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % n;
            if (k < n && mask[j[2:0]]) begin
                r.found = 1'b1;
                r.idx   = j[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Arbiter-side bundle: initiator requests and split/target handshakes in,
// grants, forward-path select and backward-path steering out.
interface bus_arbiter_rr_if import bus_pkg::*; #(
    parameter int NUM_INIT = DEF_NUM_INIT
);
    localparam int IDX_W = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;

    logic [NUM_INIT-1:0] req;
    logic                split_req;
    logic                txn_done;
    logic                split_ack;
    logic [NUM_INIT-1:0] grant;
    logic                grant_split;
    logic [IDX_W-1:0]    sel;
    logic                sel_valid;
    logic [IDX_W-1:0]    return_owner;
    logic                return_owner_valid;
    logic [NUM_INIT-1:0] split_pending;
    logic                timeout;

    modport master (
        input  req, split_req, txn_done, split_ack,
        output grant, grant_split, sel, sel_valid,
               return_owner, return_owner_valid, split_pending, timeout
    );

    modport slave (
        output req, split_req, txn_done, split_ack,
        input  grant, grant_split, sel, sel_valid,
               return_owner, return_owner_valid, split_pending, timeout
    );

endinterface

// File: rtl/bus_arbiter_rr_fifo.sv
// Ordered table of initiators waiting on split data; the head is the owner of
// the next split return. Also reports which owners currently hold an entry.
module split_owner_fifo #(
    parameter int DEPTH  = 2,
    parameter int W      = 1,
    parameter int OWNERS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [W-1:0]      din,
    output logic [W-1:0]      head,
    output logic              empty,
    output logic              full,
    output logic [OWNERS-1:0] occupancy
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_reg [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_reg[rd_ptr_reg];

    // Payload needs no reset: every read of it is qualified by valid_reg/empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                valid_reg[wr_ptr_reg] <= 1'b1;
                wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
            end
            if (pop_ok) begin
                valid_reg[rd_ptr_reg] <= 1'b0;
                rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

    genvar gi, gs;
    generate
        for (gi = 0; gi < OWNERS; gi++) begin : g_owner
            logic [DEPTH-1:0] match;
            for (gs = 0; gs < DEPTH; gs++) begin : g_slot
                assign match[gs] = valid_reg[gs] && (mem_reg[gs] == W'(gi));
            end
            assign occupancy[gi] = |match;
        end
    endgenerate

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for N initiators plus a split target, with registered
// one-hot grants, tenure timeout and FIFO steering of split returns.
module bus_arbiter_rr import bus_pkg::*; #(
    parameter int NUM_INIT  = DEF_NUM_INIT,
    parameter int NUM_SPLIT = DEF_NUM_SPLIT,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int IDX_W     = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1
) (
    input logic              clk,
    input logic              rst_n,
    bus_arbiter_rr_if.master bus
);
    localparam int                  CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit                  TO_EN   = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0]    TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [NUM_INIT-1:0] ONE     = NUM_INIT'(1);

    arb_state_e          state_reg, state_next;
    logic [IDX_W-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [NUM_INIT-1:0] grant_reg, grant_next;
    logic                grant_split_reg, grant_split_next;
    logic [IDX_W-1:0]    sel_reg, sel_next;
    logic                sel_valid_reg, sel_valid_next;
    logic                timeout_reg, timeout_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;

    logic                push, pop;
    logic [IDX_W-1:0]    head;
    logic                empty, full;
    logic [NUM_INIT-1:0] pending;
    logic [NUM_INIT-1:0] eligible;
    logic                tenure_expired;
    rr_pick_t            pick;

    split_owner_fifo #(
        .DEPTH  (NUM_SPLIT),
        .W      (IDX_W),
        .OWNERS (NUM_INIT)
    ) u_owner_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .din       (sel_reg),
        .head      (head),
        .empty     (empty),
        .full      (full),
        .occupancy (pending)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_INIT; gi++) begin : g_elig
            assign eligible[gi] = bus.req[gi] && !pending[gi] && !full;
        end
    endgenerate

    assign pick           = rr_pick(MAX_INIT'(eligible), 3'(rr_ptr_reg), NUM_INIT);
    assign tenure_expired = TO_EN && (cnt_reg == TO_LAST);

    always_comb begin
        state_next       = state_reg;
        rr_ptr_next      = rr_ptr_reg;
        grant_next       = grant_reg;
        grant_split_next = grant_split_reg;
        sel_next         = sel_reg;
        cnt_next         = cnt_reg + CNT_W'(1);
        push             = 1'b0;
        pop              = 1'b0;
        case (state_reg)
            IDLE: begin
                grant_next       = '0;
                grant_split_next = 1'b0;
                sel_next         = '0;
                cnt_next         = '0;
                if (bus.split_req && !empty) begin
                    state_next       = GNT_SPLIT;
                    grant_split_next = 1'b1;
                end else if (pick.found) begin
                    state_next  = GNT_INIT;
                    grant_next  = ONE << pick.idx;
                    sel_next    = IDX_W'(pick.idx);
                    rr_ptr_next = IDX_W'((int'(pick.idx) + 1) % NUM_INIT);
                end
            end
            GNT_INIT: begin
                if (bus.split_ack || bus.txn_done || !bus.req[sel_reg] || tenure_expired) begin
                    state_next = RELEASE;
                    grant_next = '0;
                    sel_next   = '0;
                    push       = bus.split_ack;
                end
            end
            GNT_SPLIT: begin
                // A timed-out split return still consumes its table entry.
                if (bus.txn_done || tenure_expired) begin
                    state_next       = RELEASE;
                    grant_split_next = 1'b0;
                    pop              = 1'b1;
                end
            end
            default: begin
                state_next       = IDLE;
                grant_next       = '0;
                grant_split_next = 1'b0;
                sel_next         = '0;
                cnt_next         = '0;
            end
        endcase
        sel_valid_next = |grant_next;
        // Registered pulse lands in the last granted cycle, alongside the release decision.
        timeout_next = TO_EN && (state_next == GNT_INIT || state_next == GNT_SPLIT)
                       && (cnt_next == TO_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            rr_ptr_reg      <= '0;
            grant_reg       <= '0;
            grant_split_reg <= 1'b0;
            sel_reg         <= '0;
            sel_valid_reg   <= 1'b0;
            timeout_reg     <= 1'b0;
            cnt_reg         <= '0;
        end else begin
            state_reg       <= state_next;
            rr_ptr_reg      <= rr_ptr_next;
            grant_reg       <= grant_next;
            grant_split_reg <= grant_split_next;
            sel_reg         <= sel_next;
            sel_valid_reg   <= sel_valid_next;
            timeout_reg     <= timeout_next;
            cnt_reg         <= cnt_next;
        end
    end

    assign bus.grant              = grant_reg;
    assign bus.grant_split        = grant_split_reg;
    assign bus.sel                = sel_reg;
    assign bus.sel_valid          = sel_valid_reg;
    assign bus.timeout            = timeout_reg;
    assign bus.return_owner_valid = grant_split_reg && !empty;
    assign bus.return_owner       = (grant_split_reg && !empty) ? head : '0;
    assign bus.split_pending      = pending;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr (2 initiators, 2-deep split table, TIMEOUT=8);
// inputs change and outputs are sampled on the falling clock edge.
module tb_bus_arbiter_rr;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    bus_arbiter_rr_if #(.NUM_INIT(2)) bus ();

    bus_arbiter_rr #(
        .NUM_INIT  (2),
        .NUM_SPLIT (2),
        .TIMEOUT   (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.split_req = 1'b0;
        bus.txn_done  = 1'b0;
        bus.split_ack = 1'b0;

        // Reset state
        step(); step();
        check_eq("rst_grant",      32'(bus.grant), 0);
        check_eq("rst_grant_split", 32'(bus.grant_split), 0);
        check_eq("rst_sel",        32'(bus.sel), 0);
        check_eq("rst_sel_valid",  32'(bus.sel_valid), 0);
        check_eq("rst_ret_owner",  32'(bus.return_owner), 0);
        check_eq("rst_ret_valid",  32'(bus.return_owner_valid), 0);
        check_eq("rst_pending",    32'(bus.split_pending), 0);
        check_eq("rst_timeout",    32'(bus.timeout), 0);
        rst_n = 1'b1;
        step();

        // Round robin: both request, 3-cycle tenures ended by txn_done
        bus.req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq($sformatf("rr_grant_%0d", k), 32'(bus.grant), (k % 2 == 0) ? 32'h1 : 32'h2);
            check_eq($sformatf("rr_sel_%0d", k), 32'(bus.sel), 32'(k % 2));
            step(); step();
            bus.txn_done = 1'b1;
            step();
            check_eq($sformatf("rr_release_%0d", k), 32'(bus.grant), 0);
            bus.txn_done = 1'b0;
            if (k == 3) bus.req = 2'b00;
            step();
            check_eq($sformatf("rr_idle_%0d", k), 32'(bus.grant), 0);
        end

        // Single split: init0 blocked while pending, split return steered to it
        bus.req = 2'b01;
        step();
        check_eq("sp_grant0", 32'(bus.grant), 32'h1);
        bus.split_ack = 1'b1;
        step();
        check_eq("sp_release", 32'(bus.grant), 0);
        check_eq("sp_pending", 32'(bus.split_pending), 32'h1);
        bus.split_ack = 1'b0;
        bus.req = 2'b11;
        step(); step();
        check_eq("sp_grant1_a", 32'(bus.grant), 32'h2);
        step();
        check_eq("sp_grant1_b", 32'(bus.grant), 32'h2);
        bus.txn_done = 1'b1;
        step();
        check_eq("sp_release1", 32'(bus.grant), 0);
        bus.txn_done = 1'b0;
        bus.req = 2'b01;
        step(); step();
        check_eq("sp_init0_blocked", 32'(bus.grant), 0);
        bus.req = 2'b00;
        bus.split_req = 1'b1;
        step();
        check_eq("sp_grant_split", 32'(bus.grant_split), 1);
        check_eq("sp_ret_valid",   32'(bus.return_owner_valid), 1);
        check_eq("sp_ret_owner",   32'(bus.return_owner), 0);
        bus.split_req = 1'b0;
        bus.txn_done = 1'b1;
        step();
        check_eq("sp_pending_clr", 32'(bus.split_pending), 0);
        check_eq("sp_split_rel",   32'(bus.grant_split), 0);
        bus.txn_done = 1'b0;
        step();

        // Full table blocks initiators; returns come back in split order
        bus.req = 2'b01;
        step();
        check_eq("full_grant0", 32'(bus.grant), 32'h1);
        bus.split_ack = 1'b1;
        step();
        bus.split_ack = 1'b0;
        bus.req = 2'b10;
        step(); step();
        check_eq("full_grant1", 32'(bus.grant), 32'h2);
        bus.split_ack = 1'b1;
        step();
        check_eq("full_pending", 32'(bus.split_pending), 32'h3);
        bus.split_ack = 1'b0;
        bus.req = 2'b11;
        step(); step();
        check_eq("full_no_grant_a", 32'(bus.grant), 0);
        step();
        check_eq("full_no_grant_b", 32'(bus.grant), 0);
        bus.req = 2'b00;
        bus.split_req = 1'b1;
        step();
        check_eq("full_ret_valid0", 32'(bus.return_owner_valid), 1);
        check_eq("full_ret_owner0", 32'(bus.return_owner), 0);
        bus.txn_done = 1'b1;
        step();
        check_eq("full_pending_1", 32'(bus.split_pending), 32'h2);
        bus.txn_done = 1'b0;
        step(); step();
        check_eq("full_grant_split1", 32'(bus.grant_split), 1);
        check_eq("full_ret_owner1",   32'(bus.return_owner), 1);
        bus.txn_done = 1'b1;
        bus.split_req = 1'b0;
        step();
        check_eq("full_pending_0", 32'(bus.split_pending), 0);
        bus.txn_done = 1'b0;
        step();

        // Split request beats an eligible initiator request in the same IDLE cycle
        bus.req = 2'b01;
        step();
        check_eq("prio_grant0", 32'(bus.grant), 32'h1);
        bus.split_ack = 1'b1;
        step();
        bus.split_ack = 1'b0;
        bus.req = 2'b10;
        bus.split_req = 1'b1;
        step(); step();
        check_eq("prio_grant_split", 32'(bus.grant_split), 1);
        check_eq("prio_no_init",     32'(bus.grant), 0);
        bus.split_req = 1'b0;
        bus.txn_done = 1'b1;
        step();
        bus.txn_done = 1'b0;
        step(); step();
        check_eq("prio_init_after", 32'(bus.grant), 32'h2);
        bus.txn_done = 1'b1;
        step();
        bus.txn_done = 1'b0;
        bus.req = 2'b00;
        step();

        // Timeout: held grant, no txn_done
        bus.req = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            step();
            check_eq($sformatf("to_pulse_c%0d", k), 32'(bus.timeout), (k == 8) ? 32'h1 : 32'h0);
            if (k == 8) check_eq("to_grant_c8", 32'(bus.grant), 32'h1);
        end
        step();
        check_eq("to_grant_drop", 32'(bus.grant), 0);
        check_eq("to_pulse_end",  32'(bus.timeout), 0);
        bus.req = 2'b00;
        step();

        // Asynchronous reset during a split tenure
        bus.req = 2'b01;
        step();
        bus.split_ack = 1'b1;
        step();
        bus.split_ack = 1'b0;
        bus.req = 2'b00;
        bus.split_req = 1'b1;
        step(); step();
        check_eq("ar_grant_split", 32'(bus.grant_split), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar_grant_split_0", 32'(bus.grant_split), 0);
        check_eq("ar_ret_valid_0",   32'(bus.return_owner_valid), 0);
        check_eq("ar_pending_0",     32'(bus.split_pending), 0);
        check_eq("ar_grant_0",       32'(bus.grant), 0);
        step();
        rst_n = 1'b1;
        bus.split_req = 1'b0;
        bus.req = 2'b11;
        step();
        check_eq("ar_rr_restart", 32'(bus.grant), 32'h1);
        check_eq("ar_pending_post", 32'(bus.split_pending), 0);
        bus.req = 2'b00;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
